// File: rtl/fifo_chain_pkg.sv
// fifo_chain_pkg: shared widths, stage count type and forwarding mode for fifo_chain
package fifo_chain_pkg;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int occ_w(input int stages, input int depth);
    return $clog2(stages * depth + 1);
  endfunction
  localparam int DEF_DEPTH = 4;
  typedef logic [cnt_w(DEF_DEPTH)-1:0] stage_cnt_t;
  typedef enum logic {FWD_MANUAL, FWD_AUTO} fwd_mode_e;
endpackage

// File: rtl/fifo_chain_stage.sv
// fifo_chain_stage: one FIFO stage (clk, rst active-low sync, push/pop/data_in in; head/empty/full out); caller guarantees legal push/pop
module fifo_chain_stage import fifo_chain_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (push) mem[wp] <= data_in;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  assign head  = mem[rp];
  assign empty = cnt == '0;
  assign full  = cnt == CW'(DEPTH);
endmodule

// File: rtl/fifo_chain.sv
// fifo_chain: NUM_STAGES cascaded FIFOs (clk, rst active-low sync, auto_fwd, push/data_in, pop_mask, pop_out; empty/full/data_out/out_vld/err/total_count), FIFO_CHAIN_OCC_EN enables total_count
module fifo_chain import fifo_chain_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 auto_fwd,
  input  logic                                 push,
  input  logic [WIDTH-1:0]                     data_in,
  input  logic [(NUM_STAGES>1 ? NUM_STAGES-2 : 0):0] pop_mask,
  input  logic                                 pop_out,
  output logic [NUM_STAGES-1:0]                empty,
  output logic [NUM_STAGES-1:0]                full,
  output logic [WIDTH-1:0]                     data_out,
  output logic                                 out_vld,
  output logic                                 err,
  output logic [occ_w(NUM_STAGES, DEPTH)-1:0]  total_count
);
  localparam int L  = NUM_STAGES - 1;
  localparam int TW = occ_w(NUM_STAGES, DEPTH);
  fwd_mode_e mode;
  logic [NUM_STAGES-1:0] fire;
  logic [WIDTH-1:0] head [NUM_STAGES];
  logic acc, bad;
  assign mode = fwd_mode_e'(auto_fwd);
  // Resolve pops from the output backwards so a full stage can take data in the cycle it drains
  always_comb begin
    fire    = '0;
    fire[L] = pop_out && !empty[L];
    bad     = pop_out && empty[L];
    for (int i = L - 1; i >= 0; i--) begin
      fire[i] = (mode == FWD_AUTO || pop_mask[i]) && !empty[i] && (!full[i+1] || fire[i+1]);
      bad     = bad || (mode == FWD_MANUAL && pop_mask[i] && !fire[i]);
    end
    acc = push && (!full[0] || fire[0]);
    bad = bad || (push && !acc);
  end
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    logic             st_push;
    logic [WIDTH-1:0] st_din;
    if (g == 0) begin : g_first
      assign st_push = acc;
      assign st_din  = data_in;
    end else begin : g_next
      assign st_push = fire[g-1];
      assign st_din  = head[g-1];
    end
    fifo_chain_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .push    (st_push),
      .pop     (fire[g]),
      .data_in (st_din),
      .head    (head[g]),
      .empty   (empty[g]),
      .full    (full[g])
    );
  end
  always_ff @(posedge clk)
    if (!rst) err <= 1'b0;
    else if (bad) err <= 1'b1;
  assign data_out = head[L];
  assign out_vld  = !empty[L];
`ifdef FIFO_CHAIN_OCC_EN
  logic [TW-1:0] occ;
  always_ff @(posedge clk)
    if (!rst) occ <= '0;
    else occ <= occ + TW'(acc) - TW'(fire[L]);
  assign total_count = occ;
`else
  assign total_count = '0;
`endif
endmodule

// File: tb/tb_fifo_chain.sv
// tb_fifo_chain: directed and random checks of fifo_chain against a whole-chain queue model
module tb_fifo_chain;
  localparam int NS = 3;
  localparam int D  = 4;
  logic clk = 0, rst = 0, auto_fwd = 0, push = 0, pop_out = 0;
  logic [7:0] data_in = 0;
  logic [1:0] pop_mask = 0;
  logic [2:0] empty, full;
  logic [7:0] data_out;
  logic out_vld, err;
  logic [3:0] total_count;
  int tests = 0, fails = 0;
  logic [7:0] chain [$];
  int n [NS];
  logic m_err = 0;
  always #5 clk = ~clk;
  fifo_chain #(.WIDTH(8), .DEPTH(D), .NUM_STAGES(NS)) dut (
    .clk(clk), .rst(rst), .auto_fwd(auto_fwd), .push(push), .data_in(data_in),
    .pop_mask(pop_mask), .pop_out(pop_out), .empty(empty), .full(full),
    .data_out(data_out), .out_vld(out_vld), .err(err), .total_count(total_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic model_edge();
    bit f [NS];
    bit b, a;
    if (!rst) begin
      chain.delete();
      foreach (n[i]) n[i] = 0;
      m_err = 0;
      return;
    end
    f[NS-1] = pop_out && n[NS-1] > 0;
    b = pop_out && n[NS-1] == 0;
    for (int i = NS - 2; i >= 0; i--) begin
      f[i] = (auto_fwd || pop_mask[i]) && n[i] > 0 && (n[i+1] < D || f[i+1]);
      if (!auto_fwd && pop_mask[i] && !f[i]) b = 1;
    end
    a = push && (n[0] < D || f[0]);
    if (push && !a) b = 1;
    if (f[NS-1]) begin
      void'(chain.pop_front());
      n[NS-1]--;
    end
    for (int i = NS - 2; i >= 0; i--)
      if (f[i]) begin
        n[i]--;
        n[i+1]++;
      end
    if (a) begin
      chain.push_back(data_in);
      n[0]++;
    end
    if (b) m_err = 1;
  endtask
  task automatic compare();
    logic [2:0] e, fl;
    int tot = 0;
    for (int i = 0; i < NS; i++) begin
      e[i]  = n[i] == 0;
      fl[i] = n[i] == D;
      tot  += n[i];
    end
    chk("empty", 32'(empty), 32'(e));
    chk("full", 32'(full), 32'(fl));
    chk("out_vld", 32'(out_vld), 32'(!e[NS-1]));
    chk("err", 32'(err), 32'(m_err));
    if (!e[NS-1]) chk("data_out", 32'(data_out), 32'(chain[0]));
`ifdef FIFO_CHAIN_OCC_EN
    chk("total_count", 32'(total_count), 32'(tot));
`else
    chk("total_count", 32'(total_count), 32'd0);
`endif
  endtask
  task automatic step(input logic a, input logic p, input logic [7:0] d, input logic [1:0] pm, input logic po);
    auto_fwd = a;
    push     = p;
    data_in  = d;
    pop_mask = pm;
    pop_out  = po;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask
  initial begin
    logic [7:0] want;
    step(1, 0, 0, 0, 0);
    step(1, 1, 8'h99, 0, 0);
    chk("rst_empty", 32'(empty), 32'h7);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_total", 32'(total_count), 32'h0);
    rst = 1;
    step(1, 1, 8'h11, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("lat_early", 32'(out_vld), 32'h0);
    step(1, 0, 0, 0, 0);
    chk("lat_vld", 32'(out_vld), 32'h1);
    chk("lat_data", 32'(data_out), 32'h11);
    step(1, 0, 0, 0, 1);
    for (int i = 1; i <= 12; i++) step(1, 1, 8'(i), 0, 0);
    step(1, 0, 0, 0, 0);
    chk("fill_full", 32'(full), 32'h7);
    chk("fill_empty", 32'(empty), 32'h0);
    step(1, 1, 8'hAA, 0, 1);
    chk("pass_full", 32'(full), 32'h7);
    chk("pass_err", 32'(err), 32'h0);
    chk("pass_data", 32'(data_out), 32'h02);
    step(1, 1, 8'hEE, 0, 0);
    chk("ovf_err", 32'(err), 32'h1);
    for (int i = 0; i < 12; i++) begin
      want = (i < 11) ? 8'(i + 2) : 8'hAA;
      chk("drain", 32'(data_out), 32'(want));
      step(1, 0, 0, 0, 1);
    end
    chk("drained", 32'(empty), 32'h7);
    rst = 0;
    step(0, 0, 0, 0, 0);
    rst = 1;
    step(0, 1, 8'h21, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 2'b00, 0);
    chk("man_hold", 32'(empty), 32'h6);
    step(0, 0, 0, 2'b01, 0);
    step(0, 0, 0, 2'b10, 0);
    chk("man_data", 32'(data_out), 32'h21);
    chk("man_err0", 32'(err), 32'h0);
    step(0, 0, 0, 2'b01, 0);
    step(0, 0, 0, 2'b01, 0);
    chk("man_bad", 32'(err), 32'h1);
    step(0, 0, 0, 2'b10, 1);
    step(0, 0, 0, 2'b00, 1);
    chk("err_sticky", 32'(err), 32'h1);
    for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h60 + i), 0, 0);
    rst = 0;
    step(1, 1, 8'h77, 2'b11, 1);
    chk("mid_empty", 32'(empty), 32'h7);
    chk("mid_full", 32'(full), 32'h0);
    chk("mid_err", 32'(err), 32'h0);
    chk("mid_total", 32'(total_count), 32'h0);
    rst = 1;
    step(1, 1, 8'h55, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("solo_data", 32'(data_out), 32'h55);
    step(1, 0, 0, 0, 1);
    chk("solo_empty", 32'(empty), 32'h7);
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 8'($urandom),
           2'($urandom), 1'($urandom_range(0, 2) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
